force_output_ring_node: RTL

- One node of the force return ring, the reverse direction of the position input ring.
- Accepts partial-force packets from its local PE, tagged with the home cell's gcid.
- Injects them onto the unidirectional ring, forwards transit traffic, and ejects packets addressed to its own cell to the local force cache.
- NUM_CELLS instances are chained into a ring in the top level.

---
 rtl/force_output_ring_node_pkg.sv | 42 ++++
 rtl/force_output_ring_node_fifo.sv | 45 ++++
 rtl/force_output_ring_node.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/force_output_ring_node_pkg.sv
// Shared types for the force return ring: packet layout, routing decision
// and the transit routing helper used by every ring node.
package force_output_ring_node_pkg;

   localparam int unsigned GLOBAL_CELL_ID_WIDTH = 3;
   localparam int unsigned GCID_WIDTH           = 3 * GLOBAL_CELL_ID_WIDTH;
   localparam int unsigned PARTICLE_ID_WIDTH    = 8;
   localparam int unsigned ELEMENT_WIDTH        = 2;
   localparam int unsigned FORCE_WIDTH          = 32;
   localparam int unsigned NUM_CELLS            = 8;
   localparam int unsigned HOPS_WIDTH           = $clog2(NUM_CELLS) + 1;

   typedef struct packed {
      logic [GCID_WIDTH-1:0]        dest_gcid;
      logic [PARTICLE_ID_WIDTH-1:0] parid;
      logic [ELEMENT_WIDTH-1:0]     element;
      logic [FORCE_WIDTH-1:0]       force_x;
      logic [FORCE_WIDTH-1:0]       force_y;
      logic [FORCE_WIDTH-1:0]       force_z;
      logic [HOPS_WIDTH-1:0]        hops;
   } force_ring_pkt_t;

   typedef enum logic [1:0] {
      ROUTE_HOME,
      ROUTE_NEXT,
      ROUTE_DROP
   } route_t;

   // A packet for this cell is ejected even if it also reached the hop limit.
   function automatic route_t route_transit(input force_ring_pkt_t pkt,
                                            input logic [GCID_WIDTH-1:0] gcid,
                                            input int unsigned max_hops);
      logic [HOPS_WIDTH-1:0] next_hops;
      next_hops = pkt.hops + HOPS_WIDTH'(1);
      if (pkt.dest_gcid == gcid)
         return ROUTE_HOME;
      if (next_hops == HOPS_WIDTH'(max_hops))
         return ROUTE_DROP;
      return ROUTE_NEXT;
   endfunction

endpackage

// File: rtl/force_output_ring_node_fifo.sv
// force_ring_fifo: synchronous first-word-fall-through FIFO with full/empty
// flags; no write-to-read bypass, so a pushed entry is visible next cycle.
module force_ring_fifo
   import force_output_ring_node_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter type         T     = force_ring_pkt_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   T            mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (pop && !empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/force_output_ring_node.sv
// One node of the force return ring: injects local force packets, forwards
// transit traffic, ejects own-cell packets. Optional FORCE_RING_STATS_EN adds counters.
module force_output_ring_node
   import force_output_ring_node_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned MAX_HOPS     = NUM_CELLS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [GCID_WIDTH-1:0] node_gcid,
   input  force_ring_pkt_t       local_force_pkt,
   input  logic                  local_force_valid,
   output logic                  local_force_ready,
   input  force_ring_pkt_t       prev_pkt,
   input  logic                  prev_valid,
   output logic                  prev_ready,
   output force_ring_pkt_t       next_pkt,
   output logic                  next_valid,
   input  logic                  next_ready,
   output force_ring_pkt_t       home_force_pkt,
   output logic                  home_force_valid,
   input  logic                  home_ready,
   output logic                  drop_err
`ifdef FORCE_RING_STATS_EN
   ,
   output logic [31:0]           stat_injected,
   output logic [31:0]           stat_ejected,
   output logic [31:0]           stat_forwarded
`endif
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_push;
   logic            fifo_pop;
   force_ring_pkt_t head;

   logic [SW-1:0]   starve_cnt;
   logic            starved;

   route_t          t_route;
   logic            next_ok;
   logic            home_ok;
   logic            head_home;
   logic            head_next;
   logic            forced;
   logic            tr_next;
   logic            tr_home;
   logic            tr_drop;
   logic            hd_next;
   logic            hd_home;
   logic            lost;
   force_ring_pkt_t fwd_pkt;
   force_ring_pkt_t inj_pkt;

   assign fifo_push         = local_force_valid && !fifo_full;
   assign local_force_ready = !fifo_full;

   force_ring_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (force_ring_pkt_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (local_force_pkt),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      fwd_pkt      = prev_pkt;
      fwd_pkt.hops = prev_pkt.hops + HOPS_WIDTH'(1);
      inj_pkt      = head;
      inj_pkt.hops = '0;
   end

   assign t_route   = route_transit(prev_pkt, node_gcid, MAX_HOPS);
   assign next_ok   = !next_valid || next_ready;
   assign home_ok   = !home_force_valid || home_ready;
   assign head_home = !fifo_empty && (head.dest_gcid == node_gcid);
   assign head_next = !fifo_empty && (head.dest_gcid != node_gcid);
   assign starved   = (starve_cnt == SW'(STARVE_LIMIT));

   // A starved head only claims the cycle when its own target can actually load.
   assign forced  = starved && ((head_next && next_ok) || (head_home && home_ok));

   always_comb begin
      prev_ready = 1'b0;
      case (t_route)
         ROUTE_HOME: prev_ready = home_ok && !forced;
         ROUTE_NEXT: prev_ready = next_ok && !forced;
         ROUTE_DROP: prev_ready = 1'b1;
         default:    prev_ready = 1'b0;
      endcase
   end

   assign tr_next  = prev_valid && prev_ready && (t_route == ROUTE_NEXT);
   assign tr_home  = prev_valid && prev_ready && (t_route == ROUTE_HOME);
   assign tr_drop  = prev_valid && (t_route == ROUTE_DROP);
   assign hd_next  = head_next && next_ok && !tr_next;
   assign hd_home  = head_home && home_ok && !tr_home;
   assign fifo_pop = hd_next || hd_home;
   assign lost     = (head_next && tr_next) || (head_home && tr_home);

   always_ff @(posedge clk) begin
      if (rst) begin
         next_valid <= 1'b0;
      end else if (tr_next) begin
         next_pkt   <= fwd_pkt;
         next_valid <= 1'b1;
      end else if (hd_next) begin
         next_pkt   <= inj_pkt;
         next_valid <= 1'b1;
      end else if (next_ready) begin
         next_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         home_force_valid <= 1'b0;
      end else if (tr_home) begin
         home_force_pkt   <= fwd_pkt;
         home_force_valid <= 1'b1;
      end else if (hd_home) begin
         home_force_pkt   <= inj_pkt;
         home_force_valid <= 1'b1;
      end else if (home_ready) begin
         home_force_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         drop_err   <= 1'b0;
      end else begin
         if (fifo_pop)
            starve_cnt <= '0;
         else if (lost && !starved)
            starve_cnt <= starve_cnt + SW'(1);
         if (tr_drop)
            drop_err <= 1'b1;
      end
   end

`ifdef FORCE_RING_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_injected  <= '0;
         stat_ejected   <= '0;
         stat_forwarded <= '0;
      end else begin
         if (fifo_push)
            stat_injected <= stat_injected + 32'd1;
         if (home_force_valid && home_ready)
            stat_ejected <= stat_ejected + 32'd1;
         if (next_valid && next_ready)
            stat_forwarded <= stat_forwarded + 32'd1;
      end
   end
`endif

endmodule
